// File: rtl/block_serializer.sv
// Parallel-load block serializer: latches one NUM_WORDS x WORD_W block and streams it top word
// first over valid/ready. Optional word_idx output is enabled by defining SER_WORD_IDX_EN.
module block_serializer #(
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned NUM_WORDS = 40
) (
  input  logic                        clock,
  input  logic                        reset_L,
  input  logic                        load_L,
  input  logic [WORD_W*NUM_WORDS-1:0] in,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out,
  output logic                        out_valid,
  output logic                        last,
  output logic                        busy,
`ifdef SER_WORD_IDX_EN
  output logic                        done,
  output logic [$clog2(NUM_WORDS)-1:0] word_idx
`else
  output logic                        done
`endif
);

  localparam int unsigned CntW = $clog2(NUM_WORDS);
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_WORDS - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e            state_q;
  logic [CntW-1:0]   count_q;
  logic [CntW-1:0]   count_next;
  logic [WORD_W-1:0] buf_q [NUM_WORDS];
  logic              xfer;
  logic              final_xfer;
  logic              accept;

  assign count_next = count_q + CntW'(1);
  assign xfer       = out_valid & out_ready;
  assign final_xfer = xfer & last;
  // A new block may only enter when idle or as the held block's final word leaves.
  assign accept     = ~load_L & ((state_q == StIdle) | final_xfer);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= StIdle;
      count_q <= '0;
      out     <= '0;
      last    <= 1'b0;
      done    <= 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      done <= final_xfer;
      if (accept) begin
        state_q <= StSend;
        count_q <= '0;
        out     <= in[WORD_W*NUM_WORDS-1 -: WORD_W];
        last    <= 1'b0;
        // Entry k holds the k-th word to send; entry 0 is the top word of the block.
        for (int k = 0; k < NUM_WORDS; k++) begin
          buf_q[k] <= in[WORD_W*(NUM_WORDS-k)-1 -: WORD_W];
        end
      end else if (final_xfer) begin
        state_q <= StIdle;
        last    <= 1'b0;
      end else if (xfer) begin
        count_q <= count_next;
        out     <= buf_q[count_next];
        last    <= (count_next == LastIdx);
      end
    end
  end

  assign out_valid = (state_q == StSend);
  assign busy      = (state_q == StSend);

`ifdef SER_WORD_IDX_EN
  assign word_idx = count_q;
`endif

endmodule

// File: tb/tb_block_serializer.sv
// Self-checking bench for block_serializer: random blocks, random back-pressure, reload and
// asynchronous reset scenarios checked against a word-list model of the block.
module tb_block_serializer;

  localparam int W   = 64;
  localparam int NW  = 40;
  localparam int TOT = W * NW;
  localparam int IW  = $clog2(NW);

  logic           clock;
  logic           reset_L;
  logic           load_L;
  logic [TOT-1:0] in_blk;
  logic           out_ready;
  logic [W-1:0]   out_word;
  logic           out_valid;
  logic           last;
  logic           busy;
  logic           done;
`ifdef SER_WORD_IDX_EN
  logic [IW-1:0]  word_idx;
`endif

  logic [W-1:0]   words [2][NW];
  logic [TOT-1:0] blk [2];
  int             checks;
  int             passes;

  block_serializer #(
    .WORD_W    (W),
    .NUM_WORDS (NW)
  ) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .load_L    (load_L),
    .in        (in_blk),
    .out_ready (out_ready),
    .out       (out_word),
    .out_valid (out_valid),
    .last      (last),
    .busy      (busy),
`ifdef SER_WORD_IDX_EN
    .done      (done),
    .word_idx  (word_idx)
`else
    .done      (done)
`endif
  );

  always #5 clock = ~clock;

  // mode 0: word k = k+1; mode 1: random; mode 2: random with top word 0xAA..AA.
  // The block is built the way a shift-in collector would assemble the stream.
  task automatic make_block(input int s, input int mode);
    blk[s] = '0;
    for (int k = 0; k < NW; k++) begin
      if (mode == 0) words[s][k] = W'(k + 1);
      else           words[s][k] = W'({$urandom(), $urandom()});
    end
    if (mode == 2) words[s][0] = {(W/8){8'hAA}};
    for (int k = 0; k < NW; k++) begin
      blk[s] = (blk[s] << W) | TOT'(words[s][k]);
    end
  endtask

  task automatic load_block(input int s);
    load_L    = 1'b0;
    in_blk    = blk[s];
    out_ready = 1'b1;
    @(posedge clock); #1;
    load_L = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_word, out_valid, last, busy, done} !== '0)
      $display("FAIL reset_outputs: got out=%h v=%b l=%b b=%b d=%b want all 0",
               out_word, out_valid, last, busy, done);
    else passes++;
`ifdef SER_WORD_IDX_EN
    checks++;
    if (word_idx !== '0) $display("FAIL reset_word_idx: got %0d want 0", word_idx);
    else passes++;
`endif
    @(negedge clock);
    reset_L = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({out_valid, busy, done} !== 3'b000)
      $display("FAIL idle_after_reset: got v=%b b=%b d=%b want 000", out_valid, busy, done);
    else passes++;
  endtask

  task automatic test_stream();
    make_block(0, 0);
    load_block(0);
    for (int k = 0; k < NW; k++) begin
      checks++;
      if (out_word !== words[0][k])
        $display("FAIL stream_word k=%0d: got %h want %h", k, out_word, words[0][k]);
      else passes++;
      checks++;
      if ({out_valid, last, busy, done} !== {1'b1, k == NW - 1, 1'b1, 1'b0})
        $display("FAIL stream_ctrl k=%0d: got vlbd=%b%b%b%b want 1%b10",
                 k, out_valid, last, busy, done, k == NW - 1);
      else passes++;
`ifdef SER_WORD_IDX_EN
      checks++;
      if (word_idx !== IW'(k)) $display("FAIL stream_idx: got %0d want %0d", word_idx, k);
      else passes++;
`endif
      @(posedge clock); #1;
    end
    checks++;
    if ({out_valid, last, busy, done} !== 4'b0001)
      $display("FAIL stream_done: got vlbd=%b%b%b%b want 0001", out_valid, last, busy, done);
    else passes++;
    checks++;
    if (out_word !== words[0][NW-1])
      $display("FAIL stream_hold: got %h want %h", out_word, words[0][NW-1]);
    else passes++;
    @(posedge clock); #1;
    checks++;
    if ({done, busy} !== 2'b00) $display("FAIL stream_done_pulse: got d=%b b=%b want 00", done, busy);
    else passes++;
  endtask

  task automatic test_stall();
    int         k;
    int         cyc;
    logic       rdy;
    logic [3:0] pat;
    pat = 4'b1001;
    make_block(0, 1);
    load_block(0);
    k   = 0;
    cyc = 0;
    while (k < NW && cyc < 20 * NW) begin
      checks++;
      if (out_word !== words[0][k])
        $display("FAIL stall_word k=%0d: got %h want %h", k, out_word, words[0][k]);
      else passes++;
      checks++;
      if ({out_valid, last, done} !== {1'b1, k == NW - 1, 1'b0})
        $display("FAIL stall_ctrl k=%0d: got vld=%b%b%b want 1%b0",
                 k, out_valid, last, done, k == NW - 1);
      else passes++;
`ifdef SER_WORD_IDX_EN
      checks++;
      if (word_idx !== IW'(k)) $display("FAIL stall_idx: got %0d want %0d", word_idx, k);
      else passes++;
`endif
      rdy = (cyc < 40) ? pat[3 - (cyc % 4)] : 1'($urandom_range(1, 0));
      out_ready = rdy;
      @(posedge clock); #1;
      if (rdy) k++;
      cyc++;
    end
    checks++;
    if (k !== NW) $display("FAIL stall_timeout: got %0d words want %0d", k, NW);
    else passes++;
    checks++;
    if ({out_valid, done} !== 2'b01)
      $display("FAIL stall_end: got v=%b d=%b want v=0 d=1", out_valid, done);
    else passes++;
    out_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_ignored_load();
    make_block(0, 0);
    make_block(1, 1);
    load_block(0);
    for (int k = 0; k < NW; k++) begin
      checks++;
      if (out_word !== words[0][k])
        $display("FAIL ignore_word k=%0d: got %h want %h", k, out_word, words[0][k]);
      else passes++;
      checks++;
      if ({out_valid, done} !== 2'b10)
        $display("FAIL ignore_ctrl k=%0d: got v=%b d=%b want 10", k, out_valid, done);
      else passes++;
      if (k == 9) begin
        load_L = 1'b0;
        in_blk = blk[1];
      end else begin
        load_L = 1'b1;
      end
      @(posedge clock); #1;
    end
    load_L = 1'b1;
    checks++;
    if ({out_valid, busy, done} !== 3'b001)
      $display("FAIL ignore_end: got vbd=%b%b%b want 001", out_valid, busy, done);
    else passes++;
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    logic [TOT-1:0] col;
    int             bad;
    make_block(0, 1);
    make_block(1, 2);
    load_block(0);
    for (int k = 0; k < NW; k++) begin
      checks++;
      if (out_word !== words[0][k] || done !== 1'b0)
        $display("FAIL b2b_first k=%0d: got %h d=%b want %h d=0", k, out_word, done, words[0][k]);
      else passes++;
      if (k == NW - 1) begin
        load_L = 1'b0;
        in_blk = blk[1];
      end
      @(posedge clock); #1;
    end
    load_L = 1'b1;
    checks++;
    if ({out_valid, busy, done} !== 3'b111)
      $display("FAIL b2b_switch: got vbd=%b%b%b want 111", out_valid, busy, done);
    else passes++;
    col = '0;
    for (int k = 0; k < NW; k++) begin
      checks++;
      if (out_word !== words[1][k])
        $display("FAIL b2b_word k=%0d: got %h want %h", k, out_word, words[1][k]);
      else passes++;
      if (k > 0) begin
        checks++;
        if (done !== 1'b0) $display("FAIL b2b_done_once k=%0d: got %b want 0", k, done);
        else passes++;
      end
`ifdef SER_WORD_IDX_EN
      checks++;
      if (word_idx !== IW'(k)) $display("FAIL b2b_idx: got %0d want %0d", word_idx, k);
      else passes++;
`endif
      col = (col << W) | TOT'(out_word);
      @(posedge clock); #1;
    end
    bad = -1;
    for (int k = NW - 1; k >= 0; k--) begin
      if (col[W*(NW-k)-1 -: W] !== blk[1][W*(NW-k)-1 -: W]) bad = k;
    end
    checks++;
    if (bad >= 0)
      $display("FAIL collector: word %0d got %h want %h", bad,
               col[W*(NW-bad)-1 -: W], blk[1][W*(NW-bad)-1 -: W]);
    else passes++;
    checks++;
    if ({out_valid, busy, done} !== 3'b001)
      $display("FAIL b2b_end: got vbd=%b%b%b want 001", out_valid, busy, done);
    else passes++;
    @(posedge clock); #1;
  endtask

  task automatic test_async_reset();
    make_block(0, 1);
    load_block(0);
    for (int k = 0; k < 19; k++) begin
      @(posedge clock); #1;
    end
    checks++;
    if (out_word !== words[0][19])
      $display("FAIL areset_pre: got %h want %h", out_word, words[0][19]);
    else passes++;
    #2 reset_L = 1'b0;
    #1;
    checks++;
    if ({out_word, out_valid, last, busy, done} !== '0)
      $display("FAIL areset_clear: got out=%h v=%b l=%b b=%b d=%b want all 0",
               out_word, out_valid, last, busy, done);
    else passes++;
`ifdef SER_WORD_IDX_EN
    checks++;
    if (word_idx !== '0) $display("FAIL areset_idx: got %0d want 0", word_idx);
    else passes++;
`endif
    @(negedge clock);
    reset_L = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      checks++;
      if ({out_valid, busy, done} !== 3'b000)
        $display("FAIL areset_quiet c=%0d: got vbd=%b%b%b want 000", c, out_valid, busy, done);
      else passes++;
    end
    make_block(1, 1);
    load_block(1);
    checks++;
    if (out_word !== words[1][0] || out_valid !== 1'b1)
      $display("FAIL areset_reload: got %h v=%b want %h v=1", out_word, out_valid, words[1][0]);
    else passes++;
  endtask

  initial begin
    clock     = 1'b0;
    reset_L   = 1'b0;
    load_L    = 1'b1;
    in_blk    = '0;
    out_ready = 1'b0;
    checks    = 0;
    passes    = 0;
    test_reset();
    test_stream();
    test_stall();
    test_ignored_load();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
